// File: rtl/rggen_rtl_pkg.sv
// Shared types for the register-block bus adapters: response status
// encoding, bus-stage FSM states and a counter width helper.
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        OKAY         = 2'b00,
        EXOKAY       = 2'b01,
        SLAVE_ERROR  = 2'b10,
        DECODE_ERROR = 2'b11
    } rggen_status;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_ACCESS   = 2'b01,
        ST_RESPONSE = 2'b10
    } rggen_bus_state;

    // Width that can hold 0..limit; never less than one bit.
    function automatic int unsigned counter_width(input int unsigned limit);
        int unsigned w;
        w = $clog2(limit + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rggen_access_timer.sv
// Access timeout counter. Counts cycles while i_count is high, clears on
// i_clear, and flags expiry when the count sits on its last legal value.
// A TIMEOUT_CYCLES of 0 disables counting and expiry entirely.
module rggen_access_timer
    import rggen_rtl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
)(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_count,
    output logic o_expired
);

    localparam int unsigned CW       = counter_width(TIMEOUT_CYCLES);
    localparam bit          ENABLE   = (TIMEOUT_CYCLES != 0);
    localparam int unsigned LAST_INT = ENABLE ? (TIMEOUT_CYCLES - 1) : 0;
    localparam logic [CW-1:0] LAST   = CW'(LAST_INT);

    logic [CW-1:0] count;

    // Expiry is combinational so the caller can act in the same cycle the
    // last allowed count is reached.
    assign o_expired = ENABLE && (count == LAST);

    // Count up while asked to; the caller clears before the count can
    // move past LAST, so the counter never wraps.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count <= '0;
        end else if (i_clear) begin
            count <= '0;
        end else if (ENABLE && i_count && !o_expired) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/rggen_bus_response_stage.sv
// Bus-side stage behind the register OR reducers: accepts one host request,
// presents it on the register bus, collects the reduced response (or makes
// a decode / timeout error) and holds it until the host takes it.
module rggen_bus_response_stage
    import rggen_rtl_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH  = 16,
    parameter int unsigned BUS_WIDTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
)(
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic [ADDRESS_WIDTH-1:0] i_req_address,
    input  logic                     i_req_write,
    input  logic [BUS_WIDTH-1:0]     i_req_data,
    input  logic [BUS_WIDTH-1:0]     i_req_strobe,
    output logic                     o_reg_valid,
    output logic [ADDRESS_WIDTH-1:0] o_reg_address,
    output logic                     o_reg_write,
    output logic [BUS_WIDTH-1:0]     o_reg_data,
    output logic [BUS_WIDTH-1:0]     o_reg_strobe,
    input  logic                     i_reg_active,
    input  logic                     i_reg_ready,
    input  logic [1:0]               i_reg_status,
    input  logic [BUS_WIDTH-1:0]     i_reg_read_data,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [1:0]               o_rsp_status,
    output logic [BUS_WIDTH-1:0]     o_rsp_data
);

    rggen_bus_state state;
    rggen_bus_state state_next;

    logic           capture_req;
    logic           capture_rsp;
    logic           release_rsp;
    rggen_status    rsp_status_next;
    logic [BUS_WIDTH-1:0] rsp_data_next;
    rggen_status    rsp_status;

    logic timer_count;
    logic timer_expired;

    assign o_req_ready  = (state == ST_IDLE);
    assign o_rsp_status = rsp_status;

    rggen_access_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (capture_rsp),
        .i_count   (timer_count),
        .o_expired (timer_expired)
    );

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus response selection. Within ACCESS a missing hit beats
    // ready, and ready beats timeout expiry so a late-but-real answer wins.
    always_comb begin
        state_next      = state;
        capture_req     = 1'b0;
        capture_rsp     = 1'b0;
        release_rsp     = 1'b0;
        rsp_status_next = OKAY;
        rsp_data_next   = '0;
        timer_count     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_req_valid) begin
                    capture_req = 1'b1;
                    state_next  = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!i_reg_active) begin
                    capture_rsp     = 1'b1;
                    rsp_status_next = DECODE_ERROR;
                end else if (i_reg_ready) begin
                    capture_rsp     = 1'b1;
                    rsp_status_next = rggen_status'(i_reg_status);
                    rsp_data_next   = o_reg_write ? '0 : i_reg_read_data;
                end else begin
                    timer_count = 1'b1;
                    if (timer_expired) begin
                        capture_rsp     = 1'b1;
                        rsp_status_next = SLAVE_ERROR;
                    end
                end
                if (capture_rsp) begin
                    state_next = ST_RESPONSE;
                end
            end
            ST_RESPONSE: begin
                if (i_rsp_ready) begin
                    release_rsp = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Register-bus side: latch the request on acceptance, keep the access
    // valid until a response is captured.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_reg_valid   <= 1'b0;
            o_reg_address <= '0;
            o_reg_write   <= 1'b0;
            o_reg_data    <= '0;
            o_reg_strobe  <= '0;
        end else if (capture_req) begin
            o_reg_valid   <= 1'b1;
            o_reg_address <= i_req_address;
            o_reg_write   <= i_req_write;
            o_reg_data    <= i_req_data;
            o_reg_strobe  <= i_req_strobe;
        end else if (capture_rsp) begin
            o_reg_valid   <= 1'b0;
        end
    end

    // Host side: single response buffer, held stable until accepted.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rsp_valid <= 1'b0;
            rsp_status  <= OKAY;
            o_rsp_data  <= '0;
        end else if (capture_rsp) begin
            o_rsp_valid <= 1'b1;
            rsp_status  <= rsp_status_next;
            o_rsp_data  <= rsp_data_next;
        end else if (release_rsp) begin
            o_rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rggen_bus_response_stage.sv
// Directed bench: a vector table of complete accesses driven through either
// the default-timeout instance or a TIMEOUT_CYCLES=4 instance, plus
// hand-written hold and mid-operation reset sequences.
module tb_rggen_bus_response_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic [15:0] req_address = '0;
    logic        req_write = 1'b0;
    logic [31:0] req_data = '0;
    logic [31:0] req_strobe = '0;
    logic        reg_active = 1'b0;
    logic        reg_ready = 1'b0;
    logic [1:0]  reg_status = '0;
    logic [31:0] reg_read_data = '0;
    logic        rsp_ready = 1'b0;

    logic        a_req_ready, a_reg_valid, a_reg_write, a_rsp_valid;
    logic [15:0] a_reg_address;
    logic [31:0] a_reg_data, a_reg_strobe, a_rsp_data;
    logic [1:0]  a_rsp_status;
    logic        b_req_ready, b_reg_valid, b_reg_write, b_rsp_valid;
    logic [15:0] b_reg_address;
    logic [31:0] b_reg_data, b_reg_strobe, b_rsp_data;
    logic [1:0]  b_rsp_status;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rggen_bus_response_stage dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid && !sel), .o_req_ready(a_req_ready),
        .i_req_address(req_address), .i_req_write(req_write),
        .i_req_data(req_data), .i_req_strobe(req_strobe),
        .o_reg_valid(a_reg_valid), .o_reg_address(a_reg_address),
        .o_reg_write(a_reg_write), .o_reg_data(a_reg_data), .o_reg_strobe(a_reg_strobe),
        .i_reg_active(reg_active), .i_reg_ready(reg_ready),
        .i_reg_status(reg_status), .i_reg_read_data(reg_read_data),
        .o_rsp_valid(a_rsp_valid), .i_rsp_ready(rsp_ready && !sel),
        .o_rsp_status(a_rsp_status), .o_rsp_data(a_rsp_data)
    );

    rggen_bus_response_stage #(.TIMEOUT_CYCLES(4)) dut_t (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid && sel), .o_req_ready(b_req_ready),
        .i_req_address(req_address), .i_req_write(req_write),
        .i_req_data(req_data), .i_req_strobe(req_strobe),
        .o_reg_valid(b_reg_valid), .o_reg_address(b_reg_address),
        .o_reg_write(b_reg_write), .o_reg_data(b_reg_data), .o_reg_strobe(b_reg_strobe),
        .i_reg_active(reg_active), .i_reg_ready(reg_ready),
        .i_reg_status(reg_status), .i_reg_read_data(reg_read_data),
        .o_rsp_valid(b_rsp_valid), .i_rsp_ready(rsp_ready && sel),
        .o_rsp_status(b_rsp_status), .o_rsp_data(b_rsp_data)
    );

    wire        c_req_ready   = sel ? b_req_ready   : a_req_ready;
    wire        c_reg_valid   = sel ? b_reg_valid   : a_reg_valid;
    wire [15:0] c_reg_address = sel ? b_reg_address : a_reg_address;
    wire        c_reg_write   = sel ? b_reg_write   : a_reg_write;
    wire [31:0] c_reg_data    = sel ? b_reg_data    : a_reg_data;
    wire [31:0] c_reg_strobe  = sel ? b_reg_strobe  : a_reg_strobe;
    wire        c_rsp_valid   = sel ? b_rsp_valid   : a_rsp_valid;
    wire [1:0]  c_rsp_status  = sel ? b_rsp_status  : a_rsp_status;
    wire [31:0] c_rsp_data    = sel ? b_rsp_data    : a_rsp_data;

    typedef struct {
        string       name;
        bit          sel;
        bit          wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] strobe;
        bit          active;
        int          delay;      // ready asserted in ACCESS cycle delay+1
        logic [1:0]  st;
        logic [31:0] rdata;
        logic [1:0]  exp_st;
        logic [31:0] exp_data;
        int          exp_cycles; // ACCESS cycles with o_reg_valid high
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},   64'(c_req_ready),   64'd1);
        check({tag, "_reg_valid"},   64'(c_reg_valid),   64'd0);
        check({tag, "_reg_address"}, 64'(c_reg_address), 64'd0);
        check({tag, "_reg_write"},   64'(c_reg_write),   64'd0);
        check({tag, "_reg_data"},    64'(c_reg_data),    64'd0);
        check({tag, "_reg_strobe"},  64'(c_reg_strobe),  64'd0);
        check({tag, "_rsp_valid"},   64'(c_rsp_valid),   64'd0);
        check({tag, "_rsp_status"},  64'(c_rsp_status),  64'd0);
        check({tag, "_rsp_data"},    64'(c_rsp_data),    64'd0);
    endtask

    // One complete access: request, ACCESS phase with ready after v.delay
    // cycles, response check, host acceptance.
    task automatic run_vec(input vec_t v);
        int cycles;
        @(negedge clk);
        sel         = v.sel;
        req_valid   = 1'b1;
        req_address = v.addr;
        req_write   = v.wr;
        req_data    = v.wdata;
        req_strobe  = v.strobe;
        reg_active  = 1'b0;
        reg_ready   = 1'b0;
        check({v.name, "_req_ready_idle"}, 64'(c_req_ready), 64'd1);
        @(negedge clk);
        req_valid   = 1'b0;
        req_address = ~v.addr;
        req_data    = ~v.wdata;
        check({v.name, "_reg_valid_first"}, 64'(c_reg_valid), 64'd1);
        check({v.name, "_reg_address"}, 64'(c_reg_address), 64'(v.addr));
        check({v.name, "_reg_write"}, 64'(c_reg_write), 64'(v.wr));
        check({v.name, "_reg_data"}, 64'(c_reg_data), 64'(v.wdata));
        check({v.name, "_reg_strobe"}, 64'(c_reg_strobe), 64'(v.strobe));
        cycles = 0;
        while (c_reg_valid && cycles < 200) begin
            cycles++;
            check({v.name, "_req_ready_busy"}, 64'(c_req_ready), 64'd0);
            reg_active    = v.active;
            reg_ready     = (cycles > v.delay);
            reg_status    = v.st;
            reg_read_data = v.rdata;
            @(negedge clk);
        end
        reg_active = 1'b0;
        reg_ready  = 1'b0;
        check({v.name, "_access_cycles"}, 64'(cycles), 64'(v.exp_cycles));
        check({v.name, "_rsp_valid"}, 64'(c_rsp_valid), 64'd1);
        check({v.name, "_rsp_status"}, 64'(c_rsp_status), 64'(v.exp_st));
        check({v.name, "_rsp_data"}, 64'(c_rsp_data), 64'(v.exp_data));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({v.name, "_rsp_dropped"}, 64'(c_rsp_valid), 64'd0);
        check({v.name, "_req_ready_back"}, 64'(c_req_ready), 64'd1);
    endtask

    // Bring the default instance into ACCESS (reg inputs left idle).
    task automatic start_read(input logic [15:0] addr);
        @(negedge clk);
        sel         = 1'b0;
        req_valid   = 1'b1;
        req_address = addr;
        req_write   = 1'b0;
        req_data    = 32'h0;
        req_strobe  = 32'h0;
        @(negedge clk);
        req_valid   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{"rd_okay",    1'b0, 1'b0, 16'h0010, 32'h0, 32'h0,
                    1'b1, 0, 2'b00, 32'hDEADBEEF, 2'b00, 32'hDEADBEEF, 1};
        vecs[1] = '{"wr_decode",  1'b0, 1'b1, 16'h0020, 32'h1234_5678, 32'hFFFF_0000,
                    1'b0, 0, 2'b00, 32'hAAAA_AAAA, 2'b11, 32'h0, 1};
        vecs[2] = '{"rd_exokay",  1'b0, 1'b0, 16'h0030, 32'h0, 32'h0,
                    1'b1, 5, 2'b01, 32'h1357_9BDF, 2'b01, 32'h1357_9BDF, 6};
        vecs[3] = '{"wr_slverr",  1'b0, 1'b1, 16'h0040, 32'hCAFE_0001, 32'h0000_FFFF,
                    1'b1, 2, 2'b10, 32'hFFFF_FFFF, 2'b10, 32'h0, 3};
        vecs[4] = '{"to_expire",  1'b1, 1'b0, 16'h0050, 32'h0, 32'h0,
                    1'b1, 99, 2'b00, 32'h5555_AAAA, 2'b10, 32'h0, 4};
        vecs[5] = '{"to_ready4",  1'b1, 1'b0, 16'h0060, 32'h0, 32'h0,
                    1'b1, 3, 2'b00, 32'hAAAA_5555, 2'b00, 32'hAAAA_5555, 4};

        // Reset state of both instances.
        repeat (2) @(negedge clk);
        sel = 1'b0;
        check_reset_outputs("rst_a");
        sel = 1'b1;
        check_reset_outputs("rst_b");
        sel = 1'b0;
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Response held for 10 cycles while reg inputs toggle and a new
        // request is offered.
        sel = 1'b0;
        start_read(16'h0070);
        reg_active    = 1'b1;
        reg_ready     = 1'b1;
        reg_status    = 2'b01;
        reg_read_data = 32'hCAFE_F00D;
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            check("hold_rsp_valid", 64'(c_rsp_valid), 64'd1);
            check("hold_rsp_status", 64'(c_rsp_status), 64'd1);
            check("hold_rsp_data", 64'(c_rsp_data), 64'hCAFE_F00D);
            check("hold_req_ready", 64'(c_req_ready), 64'd0);
            check("hold_reg_valid", 64'(c_reg_valid), 64'd0);
            req_valid     = 1'b1;
            req_address   = 16'(k * 4);
            reg_active    = k[0];
            reg_ready     = k[1];
            reg_status    = 2'(k);
            reg_read_data = $urandom;
            @(negedge clk);
        end
        req_valid  = 1'b0;
        reg_active = 1'b0;
        reg_ready  = 1'b0;
        check("hold_addr_kept", 64'(c_reg_address), 64'h0070);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("hold_released", 64'(c_rsp_valid), 64'd0);
        check("hold_idle", 64'(c_req_ready), 64'd1);

        // Reset pulsed in ACCESS.
        start_read(16'h0080);
        reg_active = 1'b1;
        reg_ready  = 1'b0;
        check("mid_access_valid", 64'(c_reg_valid), 64'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_access");
        @(negedge clk);
        rst = 1'b0;
        reg_active = 1'b0;

        // Reset pulsed in RESPONSE.
        start_read(16'h0090);
        reg_active    = 1'b1;
        reg_ready     = 1'b1;
        reg_status    = 2'b01;
        reg_read_data = 32'h0BAD_0BAD;
        @(negedge clk);
        reg_active = 1'b0;
        reg_ready  = 1'b0;
        check("mid_rsp_valid", 64'(c_rsp_valid), 64'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_response");
        @(negedge clk);
        rst = 1'b0;

        // Normal access after reset.
        run_vec(vecs[0]);
        sel = 1'b1;
        run_vec(vecs[5]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
